// File: rtl/peripheral_bin2bcd_pkg.sv
// rtl/peripheral_bin2bcd_pkg.sv - shared constants, FSM states and double-dabble step
package peripheral_bin2bcd_pkg;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_INIT   = 3'd1;
  localparam logic [2:0] ADDR_READY  = 3'd2;
  localparam logic [2:0] ADDR_RES_DN = 3'd3;
  localparam logic [2:0] ADDR_RES_UP = 3'd4;

  localparam int BCD_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One double-dabble bit: correct every digit >= 5, then shift the new bit in.
  function automatic logic [4*BCD_DIGITS-1:0] dabble(input logic [4*BCD_DIGITS-1:0] acc,
                                                     input logic b);
    logic [4*BCD_DIGITS-1:0] adj;
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[4*BCD_DIGITS-2:0], b};
  endfunction

endpackage

// File: rtl/peripheral_bin2bcd_core.sv
// rtl/peripheral_bin2bcd_core.sv - 32-bit binary to 10-digit BCD converter, 2 bits per cycle
module bin2bcd_core
  import peripheral_bin2bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic [39:0] bcd,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] acc_q, acc_d;
  logic [39:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    case (state_q)
      LOAD: begin
        bin_d  = bin;
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      SHIFT: begin
        acc_d = dabble(dabble(acc_q, bin_q[31]), bin_q[30]);
        bin_d = {bin_q[29:0], 2'b00};
        cnt_d = cnt_q + 4'd1;
      end
      DONE: begin
        res_d  = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // In DONE the finished accumulator is forwarded so software sees it one cycle early.
  always_comb begin
    busy = (state_q == LOAD) || (state_q == SHIFT);
    done = (state_q == DONE) || (done_q && (state_q == IDLE));
    bcd  = (state_q == DONE) ? acc_q : res_q;
  end

endmodule

// File: rtl/peripheral_bin2bcd.sv
// rtl/peripheral_bin2bcd.sv - bus-mapped wrapper: operand register, start decode, read mux
module peripheral_bin2bcd
  import peripheral_bin2bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  logic [31:0] a_q, a_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] rdata;
  logic [39:0] bcd;
  logic        busy;
  logic        done;
  logic        start;

  assign start = cs && wr && (addr == ADDR_INIT) && d_in[0];

  bin2bcd_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (a_q),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  always_comb begin
    case (addr)
      ADDR_A:      rdata = a_q;
      ADDR_INIT:   rdata = {31'b0, busy};
      ADDR_READY:  rdata = {31'b0, done};
      ADDR_RES_DN: rdata = bcd[31:0];
      ADDR_RES_UP: rdata = {24'b0, bcd[39:32]};
      default:     rdata = '0;
    endcase
  end

  // Read data is taken from pre-edge state, so a combined rd/wr returns the old value.
  always_comb begin
    a_d    = a_q;
    dout_d = dout_q;
    if (cs && wr && (addr == ADDR_A)) a_d = d_in;
    if (cs && rd) dout_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      dout_q <= '0;
    end else begin
      a_q    <= a_d;
      dout_q <= dout_d;
    end
  end

  assign d_out = dout_q;

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// tb/tb_peripheral_bin2bcd.sv - directed self-checking bench for peripheral_bin2bcd
module tb_peripheral_bin2bcd;

  logic        clk;
  logic        rst;
  logic [31:0] d_in;
  logic        cs;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;
  int          total;
  int          bad;

  peripheral_bin2bcd dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    check(tag, d_out, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic convert(input logic [31:0] val);
    bus_write(3'd0, val);
    bus_write(3'd1, 32'h1);
    idle(17);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; d_in = '0;
    idle(2);
    check("reset_dout", d_out, 32'h0);
    rst = 1'b0;
    expect_read("reset_ready", 3'd2, 32'h0);
    expect_read("reset_res_dn", 3'd3, 32'h0);
    expect_read("reset_res_up", 3'd4, 32'h0);

    // 4000, with status polls, an A rewrite and an ignored second start mid-run
    bus_write(3'd0, 32'h0000_0FA0);
    expect_read("a_readback", 3'd0, 32'h0000_0FA0);
    bus_write(3'd1, 32'h1);
    expect_read("busy_after_start", 3'd1, 32'h1);
    expect_read("ready_after_start", 3'd2, 32'h0);
    bus_write(3'd0, 32'h5);
    bus_write(3'd1, 32'h1);
    idle(13);
    expect_read("ready_4000", 3'd2, 32'h1);
    expect_read("res_dn_4000", 3'd3, 32'h0000_4000);
    expect_read("res_up_4000", 3'd4, 32'h0);
    expect_read("busy_clear", 3'd1, 32'h0);
    expect_read("a_midrun_write", 3'd0, 32'h5);

    bus_write(3'd1, 32'h1);
    idle(17);
    expect_read("ready_5", 3'd2, 32'h1);
    expect_read("res_dn_5", 3'd3, 32'h5);

    convert(32'hFFFF_FFFF);
    expect_read("res_dn_max", 3'd3, 32'h9496_7295);
    expect_read("res_up_max", 3'd4, 32'h0000_0042);

    convert(32'h0);
    expect_read("ready_zero", 3'd2, 32'h1);
    expect_read("res_dn_zero", 3'd3, 32'h0);
    expect_read("res_up_zero", 3'd4, 32'h0);

    // reset in the middle of a conversion
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'h1);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrun_reset_dout", d_out, 32'h0);
    expect_read("midrun_reset_ready", 3'd2, 32'h0);
    expect_read("midrun_reset_busy", 3'd1, 32'h0);
    expect_read("midrun_reset_dn", 3'd3, 32'h0);
    expect_read("midrun_reset_up", 3'd4, 32'h0);
    expect_read("midrun_reset_a", 3'd0, 32'h0);

    convert(32'h075B_CD15);
    expect_read("ready_123456789", 3'd2, 32'h1);
    expect_read("res_dn_123456789", 3'd3, 32'h2345_6789);
    expect_read("res_up_123456789", 3'd4, 32'h0000_0001);

    for (int a = 5; a < 8; a++) expect_read("unmapped_read", 3'(a), 32'h0);

    // d_out holds when cs is low
    expect_read("res_dn_again", 3'd3, 32'h2345_6789);
    cs = 1'b0; rd = 1'b1; addr = 3'd5;
    idle(2);
    rd = 1'b0;
    check("hold_without_cs", d_out, 32'h2345_6789);

    // simultaneous read and write returns the pre-write value
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd0; d_in = 32'h7;
    idle(1);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check("rdwr_old_value", d_out, 32'h075B_CD15);
    expect_read("rdwr_new_value", 3'd0, 32'h7);

    // writing 0 to INIT does not start anything
    bus_write(3'd1, 32'h0);
    expect_read("init0_busy", 3'd1, 32'h0);
    idle(17);
    expect_read("init0_ready", 3'd2, 32'h1);
    expect_read("init0_res_dn", 3'd3, 32'h2345_6789);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
